// File: rtl/scr1_dmem_tcm_resp_pkg.sv
// Shared definitions for the DMEM tightly-coupled memory responder.
//  - memory interface enums (command, width, response)
//  - responder FSM state type
//  - byte-enable helper
//  - default base address and depth
package scr1_dmem_tcm_resp_pkg;

    localparam int unsigned SCR1_DMEM_AWIDTH         = 32;
    localparam int unsigned SCR1_DMEM_DWIDTH         = 32;
    localparam logic [31:0] SCR1_DMEM_TCM_BASE_DEF   = 32'h0001_0000;
    localparam int unsigned SCR1_DMEM_TCM_DEPTH_DEF  = 1024;

    typedef enum logic [1:0] {
        SCR1_MEM_CMD_RD    = 2'b00,
        SCR1_MEM_CMD_WR    = 2'b01,
        SCR1_MEM_CMD_ERROR = 2'b11
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    typedef enum logic [1:0] {
        SCR1_DMEM_TCM_FSM_IDLE = 2'b00,
        SCR1_DMEM_TCM_FSM_WAIT = 2'b01,
        SCR1_DMEM_TCM_FSM_RESP = 2'b10
    } type_scr1_dmem_tcm_fsm_e;

    // Lane enables for a store of the given width at byte offset off.
    function automatic logic [3:0] scr1_dmem_tcm_be(input type_scr1_mem_width_e width,
                                                    input logic [1:0]           off);
        logic [3:0] be;
        case (width)
            SCR1_MEM_WIDTH_BYTE:  be = 4'b0001 << off;
            SCR1_MEM_WIDTH_HWORD: be = 4'b0011 << off;
            SCR1_MEM_WIDTH_WORD:  be = 4'b1111;
            default:              be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/scr1_dmem_tcm_ram.sv
// Inferred synchronous single-port data RAM, 32-bit words, 4 byte enables.
// Read data appears one cycle after re and holds until the next read.
// The array is not reset.
// Ports:
//  clk    core clock
//  re     read enable
//  we     write enable (byte lanes selected by be)
//  addr   word index
//  be     byte enables
//  wdata  lane-aligned write data
//  rdata  registered read word
module scr1_dmem_tcm_ram #(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           re,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [3:0]                     be,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/scr1_dmem_tcm_resp.sv
// DMEM responder fronting the data TCM. One request at a time, WAIT_STATES extra
// response cycles, OK/ER responses, right-aligned zero-extended load data and
// lane-shifted store data.
// Optional feature macro: SCR1_DMEM_TCM_RO_EN -- writes overlapping
// [RO_BASE, RO_BASE+RO_SIZE) are rejected with RDY_ER and not performed.
// Ports:
//  clk, rst_n     clock, async active-low reset
//  dmem_req       request valid
//  dmem_cmd       RD/WR
//  dmem_width     BYTE/HWORD/WORD
//  dmem_addr      byte address
//  dmem_wdata     low-aligned store data
//  dmem_req_ack   request accepted (high in IDLE)
//  dmem_rdata     load data, valid in the response cycle only
//  dmem_resp      NOTRDY/RDY_OK/RDY_ER
module scr1_dmem_tcm_resp
    import scr1_dmem_tcm_resp_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = SCR1_DMEM_TCM_DEPTH_DEF,
    parameter logic [31:0] BASE_ADDR   = SCR1_DMEM_TCM_BASE_DEF,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] RO_BASE     = 32'h0001_0000,
    parameter logic [31:0] RO_SIZE     = 32'h0000_0100
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        dmem_req,
    input  type_scr1_mem_cmd_e          dmem_cmd,
    input  type_scr1_mem_width_e        dmem_width,
    input  logic [SCR1_DMEM_AWIDTH-1:0] dmem_addr,
    input  logic [SCR1_DMEM_DWIDTH-1:0] dmem_wdata,
    output logic                        dmem_req_ack,
    output logic [SCR1_DMEM_DWIDTH-1:0] dmem_rdata,
    output type_scr1_mem_resp_e         dmem_resp
);

    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SIZE_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  WAIT_INIT  = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    type_scr1_dmem_tcm_fsm_e state_q;
    logic [3:0]              cnt_q;
    type_scr1_mem_resp_e     resp_q;
    type_scr1_mem_cmd_e      cmd_q;
    type_scr1_mem_width_e    width_q;
    logic [1:0]              off_q;
    logic                    err_q;

    logic [31:0] rel_addr;
    logic        range_err, align_err, width_err, cmd_err, ro_err, req_err;
    logic        accept;
    logic [31:0] ram_rdata, rd_shift;

    assign dmem_req_ack = (state_q == SCR1_DMEM_TCM_FSM_IDLE);
    assign accept       = dmem_req & dmem_req_ack;

    // Unsigned offset: addresses below the base wrap high and fail the range check.
    assign rel_addr  = dmem_addr - BASE_ADDR;
    assign range_err = (rel_addr >= SIZE_BYTES);
    assign cmd_err   = (dmem_cmd != SCR1_MEM_CMD_RD) && (dmem_cmd != SCR1_MEM_CMD_WR);

    always_comb begin
        align_err = 1'b0;
        width_err = 1'b0;
        case (dmem_width)
            SCR1_MEM_WIDTH_BYTE:  align_err = 1'b0;
            SCR1_MEM_WIDTH_HWORD: align_err = dmem_addr[0];
            SCR1_MEM_WIDTH_WORD:  align_err = |dmem_addr[1:0];
            default:              width_err = 1'b1;
        endcase
    end

`ifdef SCR1_DMEM_TCM_RO_EN
    logic [32:0] req_lo, req_hi, ro_lo, ro_hi;
    logic [2:0]  req_len;

    always_comb begin
        case (dmem_width)
            SCR1_MEM_WIDTH_BYTE:  req_len = 3'd1;
            SCR1_MEM_WIDTH_HWORD: req_len = 3'd2;
            default:              req_len = 3'd4;
        endcase
    end

    // 33-bit interval arithmetic so regions touching the top of memory do not wrap.
    assign req_lo = {1'b0, dmem_addr};
    assign req_hi = req_lo + 33'(req_len);
    assign ro_lo  = {1'b0, RO_BASE};
    assign ro_hi  = ro_lo + {1'b0, RO_SIZE};
    assign ro_err = (dmem_cmd == SCR1_MEM_CMD_WR) && (req_lo < ro_hi) && (req_hi > ro_lo);
`else
    assign ro_err = 1'b0;
`endif

    assign req_err = range_err | align_err | width_err | cmd_err | ro_err;

    scr1_dmem_tcm_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk   (clk),
        .re    (accept & (dmem_cmd == SCR1_MEM_CMD_RD) & ~req_err),
        .we    (accept & (dmem_cmd == SCR1_MEM_CMD_WR) & ~req_err),
        .addr  (rel_addr[IDX_W+1:2]),
        .be    (scr1_dmem_tcm_be(dmem_width, dmem_addr[1:0])),
        .wdata (dmem_wdata << {dmem_addr[1:0], 3'b000}),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SCR1_DMEM_TCM_FSM_IDLE;
            cnt_q   <= 4'd0;
            resp_q  <= SCR1_MEM_RESP_NOTRDY;
            cmd_q   <= SCR1_MEM_CMD_RD;
            width_q <= SCR1_MEM_WIDTH_BYTE;
            off_q   <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                SCR1_DMEM_TCM_FSM_IDLE: begin
                    if (dmem_req) begin
                        cmd_q   <= dmem_cmd;
                        width_q <= dmem_width;
                        off_q   <= dmem_addr[1:0];
                        err_q   <= req_err;
                        if (WAIT_STATES == 0) begin
                            state_q <= SCR1_DMEM_TCM_FSM_RESP;
                            resp_q  <= req_err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
                        end else begin
                            state_q <= SCR1_DMEM_TCM_FSM_WAIT;
                            cnt_q   <= WAIT_INIT;
                        end
                    end
                end
                SCR1_DMEM_TCM_FSM_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= SCR1_DMEM_TCM_FSM_RESP;
                        resp_q  <= err_q ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                SCR1_DMEM_TCM_FSM_RESP: begin
                    state_q <= SCR1_DMEM_TCM_FSM_IDLE;
                    resp_q  <= SCR1_MEM_RESP_NOTRDY;
                end
                default: begin
                    state_q <= SCR1_DMEM_TCM_FSM_IDLE;
                    resp_q  <= SCR1_MEM_RESP_NOTRDY;
                end
            endcase
        end
    end

    assign dmem_resp = resp_q;

    // RAM output is held since the accept cycle, so it is still valid in RESP.
    assign rd_shift = ram_rdata >> {off_q, 3'b000};

    always_comb begin
        dmem_rdata = '0;
        if ((state_q == SCR1_DMEM_TCM_FSM_RESP) && !err_q && (cmd_q == SCR1_MEM_CMD_RD)) begin
            case (width_q)
                SCR1_MEM_WIDTH_BYTE:  dmem_rdata = {24'd0, rd_shift[7:0]};
                SCR1_MEM_WIDTH_HWORD: dmem_rdata = {16'd0, rd_shift[15:0]};
                SCR1_MEM_WIDTH_WORD:  dmem_rdata = rd_shift;
                default:              dmem_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_scr1_dmem_tcm_resp.sv
// Scoreboard bench: two responders (0 and 3 wait states) driven with directed and
// random traffic; a byte-level memory model predicts responses, a monitor checks them.
module tb_scr1_dmem_tcm_resp;
    import scr1_dmem_tcm_resp_pkg::*;

    localparam int unsigned DEPTH   = 64;
    localparam logic [31:0] BASE    = 32'h0001_0000;
    localparam logic [31:0] RO_BASE = BASE + 32'h80;
    localparam logic [31:0] RO_SIZE = 32'h10;

    typedef struct {
        int          due;
        logic [1:0]  resp;
        logic [31:0] rdata;
        bit          chk_data;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 req   [2];
    type_scr1_mem_cmd_e   cmd   [2];
    type_scr1_mem_width_e width [2];
    logic [31:0]          addr  [2];
    logic [31:0]          wdata [2];
    logic                 ack   [2];
    logic [31:0]          rdata [2];
    type_scr1_mem_resp_e  resp  [2];

    int   cyc = 0;
    int   next_ok [2];
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q0[$];
    exp_t exp_q1[$];
    logic [7:0] mem_m   [2][DEPTH*4];
    bit         known_m [2][DEPTH*4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    scr1_dmem_tcm_resp #(
        .DEPTH_WORDS (DEPTH), .BASE_ADDR (BASE), .WAIT_STATES (0),
        .RO_BASE (RO_BASE), .RO_SIZE (RO_SIZE)
    ) dut0 (
        .clk (clk), .rst_n (rst_n), .dmem_req (req[0]), .dmem_cmd (cmd[0]),
        .dmem_width (width[0]), .dmem_addr (addr[0]), .dmem_wdata (wdata[0]),
        .dmem_req_ack (ack[0]), .dmem_rdata (rdata[0]), .dmem_resp (resp[0])
    );

    scr1_dmem_tcm_resp #(
        .DEPTH_WORDS (DEPTH), .BASE_ADDR (BASE), .WAIT_STATES (3),
        .RO_BASE (RO_BASE), .RO_SIZE (RO_SIZE)
    ) dut3 (
        .clk (clk), .rst_n (rst_n), .dmem_req (req[1]), .dmem_cmd (cmd[1]),
        .dmem_width (width[1]), .dmem_addr (addr[1]), .dmem_wdata (wdata[1]),
        .dmem_req_ack (ack[1]), .dmem_rdata (rdata[1]), .dmem_resp (resp[1])
    );

    function automatic int waits(int k);
        return (k == 0) ? 0 : 3;
    endfunction

    function automatic void chk(string name, int k, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d @cyc %0d: got %h, expected %h", name, k, cyc, act, exp);
        end
    endfunction

    function automatic int q_size(int k);
        return (k == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic exp_t q_pop(int k);
        return (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
    endfunction

    function automatic int q_head_due(int k);
        return (k == 0) ? exp_q0[0].due : exp_q1[0].due;
    endfunction

    // Reference model: byte-addressed memory, error rules applied directly.
    function automatic exp_t predict(int k, type_scr1_mem_cmd_e c, type_scr1_mem_width_e w,
                                     logic [31:0] a, logic [31:0] d);
        exp_t        e;
        logic [31:0] rel;
        int unsigned size;
        bit          err;
        rel = a - BASE;
        err = 0;
        size = 1;
        case (w)
            SCR1_MEM_WIDTH_BYTE:  size = 1;
            SCR1_MEM_WIDTH_HWORD: begin size = 2; if (a % 2 != 0) err = 1; end
            SCR1_MEM_WIDTH_WORD:  begin size = 4; if (a % 4 != 0) err = 1; end
            default:              err = 1;
        endcase
        if (c != SCR1_MEM_CMD_RD && c != SCR1_MEM_CMD_WR) err = 1;
        if (rel >= DEPTH * 4) err = 1;
`ifdef SCR1_DMEM_TCM_RO_EN
        if (c == SCR1_MEM_CMD_WR && (64'(a) < 64'(RO_BASE) + 64'(RO_SIZE))
            && (64'(a) + 64'(size) > 64'(RO_BASE))) err = 1;
`endif
        e.rdata = 32'd0;
        e.chk_data = 1;
        if (err) begin
            e.resp = SCR1_MEM_RESP_RDY_ER;
        end else if (c == SCR1_MEM_CMD_WR) begin
            e.resp = SCR1_MEM_RESP_RDY_OK;
            e.chk_data = 0;
            for (int i = 0; i < int'(size); i++) begin
                mem_m[k][int'(rel) + i]   = d[8*i +: 8];
                known_m[k][int'(rel) + i] = 1;
            end
        end else begin
            e.resp = SCR1_MEM_RESP_RDY_OK;
            for (int i = 0; i < int'(size); i++) begin
                if (!known_m[k][int'(rel) + i]) e.chk_data = 0;
                e.rdata[8*i +: 8] = mem_m[k][int'(rel) + i];
            end
        end
        return e;
    endfunction

    task automatic issue(int k, type_scr1_mem_cmd_e c, type_scr1_mem_width_e w,
                         logic [31:0] a, logic [31:0] d);
        exp_t e;
        int   tries;
        bit   done;
        @(negedge clk);
        req[k] = 1'b1; cmd[k] = c; width[k] = w; addr[k] = a; wdata[k] = d;
        done = 0;
        tries = 0;
        while (!done) begin
            #1;
            chk("ack", k, 32'(ack[k]), 32'(cyc >= next_ok[k]));
            if (ack[k]) begin
                e = predict(k, c, w, a, d);
                e.due = cyc + 1 + waits(k);
                if (k == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
                next_ok[k] = cyc + 2 + waits(k);
                done = 1;
                @(posedge clk);
                #1 req[k] = 1'b0;
            end else begin
                tries++;
                if (tries > 40) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL ack_timeout dut%0d: got no ack, expected ack within 40 cycles", k);
                    req[k] = 1'b0;
                    done = 1;
                end else begin
                    @(negedge clk);
                end
            end
        end
    endtask

    task automatic check_reset_outputs();
        for (int k = 0; k < 2; k++) begin
            chk("reset_resp", k, 32'(resp[k]), 32'(SCR1_MEM_RESP_NOTRDY));
            chk("reset_rdata", k, rdata[k], 32'd0);
            chk("reset_ack", k, 32'(ack[k]), 32'd1);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3 rst_n = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        #1 check_reset_outputs();
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1;
        next_ok[0] = cyc;
        next_ok[1] = cyc;
    endtask

    // Monitor: pops the scoreboard whenever a DUT presents a response.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            for (int k = 0; k < 2; k++) begin
                if (resp[k] != SCR1_MEM_RESP_NOTRDY) begin
                    if (q_size(k) == 0) begin
                        chk("unexpected_resp", k, 32'(resp[k]), 32'(SCR1_MEM_RESP_NOTRDY));
                    end else begin
                        e = q_pop(k);
                        chk("resp_cycle", k, 32'(cyc), 32'(e.due));
                        chk("resp_code", k, 32'(resp[k]), 32'(e.resp));
                        if (e.chk_data) chk("rdata", k, rdata[k], e.rdata);
                    end
                end else if (q_size(k) > 0 && q_head_due(k) < cyc) begin
                    e = q_pop(k);
                    chk("missing_resp", k, 32'(resp[k]), 32'(e.resp));
                end
            end
        end
    end

    initial begin
        type_scr1_mem_cmd_e   rc;
        type_scr1_mem_width_e rw;
        logic [31:0]          ra;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req[k] = 1'b0; cmd[k] = SCR1_MEM_CMD_RD; width[k] = SCR1_MEM_WIDTH_WORD;
            addr[k] = BASE; wdata[k] = 32'd0; next_ok[k] = 0;
            for (int i = 0; i < DEPTH * 4; i++) known_m[k][i] = 0;
        end
        repeat (3) @(negedge clk);
        check_reset_outputs();
        #3 rst_n = 1'b1;
        next_ok[0] = cyc;
        next_ok[1] = cyc;

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < int'(DEPTH); i++)
                issue(k, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, BASE + 32'(4 * i), $urandom);

            issue(k, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, BASE, 32'hDEAD_BEEF);
            issue(k, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, BASE, 32'd0);
            issue(k, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, BASE + 3, 32'h0000_00A5);
            issue(k, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, BASE, 32'd0);
            issue(k, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE, BASE + 3, 32'd0);
            issue(k, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, BASE + 2, 32'd0);
            issue(k, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, BASE + DEPTH * 4, 32'd0);
            issue(k, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, BASE - 4, 32'd0);
            issue(k, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, BASE + 1, 32'h0000_1234);
            issue(k, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, BASE, 32'd0);
            issue(k, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, RO_BASE, 32'h1234_5678);
            issue(k, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, RO_BASE, 32'd0);
            issue(k, type_scr1_mem_cmd_e'(2'b10), SCR1_MEM_WIDTH_WORD, BASE + 8, 32'd0);
            issue(k, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_ERROR, BASE + 8, 32'd0);

            for (int n = 0; n < 150; n++) begin
                rc = ($urandom_range(0, 15) == 0) ? SCR1_MEM_CMD_ERROR
                   : (($urandom_range(0, 1) == 0) ? SCR1_MEM_CMD_RD : SCR1_MEM_CMD_WR);
                rw = ($urandom_range(0, 9) == 0) ? SCR1_MEM_WIDTH_ERROR
                   : type_scr1_mem_width_e'($urandom_range(0, 2));
                ra = BASE - 8 + $urandom_range(0, DEPTH * 4 + 16);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                issue(k, rc, rw, ra, $urandom);
            end

            if (k == 1) begin
                // Write committed at accept, then reset lands in the wait phase.
                issue(k, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, BASE + 20, 32'hCAFE_F00D);
                do_reset();
                issue(k, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, BASE + 20, 32'd0);
                issue(k, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, BASE, 32'd0);
            end
            repeat (10) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
